// File: rtl/wb_register_file.sv
// Writeback-stage register file: fifteen 32-bit GPRs, R15 read as PC_In + PC_OFFSET,
// R15 writes turned into a registered one-cycle branch request, plus a saturating writeback counter.
module wb_register_file #(
  parameter logic [31:0] PC_OFFSET = 32'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] DataIn,
  input  logic [31:0] NonLoadDataIn,
  input  logic [3:0]  Rd_In,
  input  logic        LoadInst,
  input  logic        RF_EN,
  input  logic [3:0]  RA,
  input  logic [3:0]  RB,
  input  logic [3:0]  RC,
  output logic [31:0] PA,
  output logic [31:0] PB,
  output logic [31:0] PC_Out,
  input  logic [31:0] PC_In,
  output logic        PC_Load,
  output logic [31:0] PC_Target,
  output logic [15:0] wb_count
);

  logic [31:0] regs_r [0:14];
  logic        pc_load_r;
  logic [31:0] pc_target_r;
  logic [15:0] wb_count_r;

  logic [31:0] wb_data_s;
  logic [31:0] pc_read_s;
  logic        accept_s;
  logic        bypass_en_s;

  assign wb_data_s   = LoadInst ? DataIn : NonLoadDataIn;
  assign pc_read_s   = PC_In + PC_OFFSET;
  assign accept_s    = RF_EN & ~reset;
  // Forwarding only applies to array registers; R15 reads always see the fetch PC.
  assign bypass_en_s = accept_s & (Rd_In != 4'd15);

  // Port A read mux: PC view, same-cycle bypass, or stored value.
  always_comb begin
    PA = 32'd0;
    if (RA == 4'd15) begin
      PA = pc_read_s;
    end else if (bypass_en_s && (RA == Rd_In)) begin
      PA = wb_data_s;
    end else begin
      PA = regs_r[RA];
    end
  end

  // Port B read mux.
  always_comb begin
    PB = 32'd0;
    if (RB == 4'd15) begin
      PB = pc_read_s;
    end else if (bypass_en_s && (RB == Rd_In)) begin
      PB = wb_data_s;
    end else begin
      PB = regs_r[RB];
    end
  end

  // Port C (store data) read mux.
  always_comb begin
    PC_Out = 32'd0;
    if (RC == 4'd15) begin
      PC_Out = pc_read_s;
    end else if (bypass_en_s && (RC == Rd_In)) begin
      PC_Out = wb_data_s;
    end else begin
      PC_Out = regs_r[RC];
    end
  end

  // Register array, branch request and writeback counter; reset discards any concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 15; i++) begin
        regs_r[i] <= 32'd0;
      end
      pc_load_r   <= 1'b0;
      pc_target_r <= 32'd0;
      wb_count_r  <= 16'd0;
    end else begin
      pc_load_r <= 1'b0;
      if (RF_EN) begin
        if (Rd_In == 4'd15) begin
          pc_load_r   <= 1'b1;
          pc_target_r <= wb_data_s;
        end else begin
          regs_r[Rd_In] <= wb_data_s;
        end
        if (wb_count_r != 16'hFFFF) begin
          wb_count_r <= wb_count_r + 16'd1;
        end else begin
          wb_count_r <= wb_count_r;
        end
      end else begin
        pc_target_r <= pc_target_r;
      end
    end
  end

  assign PC_Load   = pc_load_r;
  assign PC_Target = pc_target_r;
  assign wb_count  = wb_count_r;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed self-checking bench for wb_register_file: one task per feature, hand-computed expectations.
module tb_wb_register_file;

  logic        clk;
  logic        reset;
  logic [31:0] DataIn;
  logic [31:0] NonLoadDataIn;
  logic [3:0]  Rd_In;
  logic        LoadInst;
  logic        RF_EN;
  logic [3:0]  RA;
  logic [3:0]  RB;
  logic [3:0]  RC;
  logic [31:0] PA;
  logic [31:0] PB;
  logic [31:0] PC_Out;
  logic [31:0] PC_In;
  logic        PC_Load;
  logic [31:0] PC_Target;
  logic [15:0] wb_count;

  int checks;
  int errors;

  wb_register_file #(.PC_OFFSET(32'd8)) dut (
    .clk(clk), .reset(reset), .DataIn(DataIn), .NonLoadDataIn(NonLoadDataIn),
    .Rd_In(Rd_In), .LoadInst(LoadInst), .RF_EN(RF_EN), .RA(RA), .RB(RB), .RC(RC),
    .PA(PA), .PB(PB), .PC_Out(PC_Out), .PC_In(PC_In), .PC_Load(PC_Load),
    .PC_Target(PC_Target), .wb_count(wb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; RF_EN = 1'b0; LoadInst = 1'b0; DataIn = 32'd0; NonLoadDataIn = 32'd0;
    Rd_In = 4'd0; RA = 4'd0; RB = 4'd0; RC = 4'd0; PC_In = 32'd0;
    tick(); tick();
    checks++; if (PC_Load !== 1'b0) begin errors++; $display("FAIL reset_pc_load got %0h want 0", PC_Load); end
    checks++; if (PC_Target !== 32'd0) begin errors++; $display("FAIL reset_pc_target got %0h want 0", PC_Target); end
    checks++; if (wb_count !== 16'd0) begin errors++; $display("FAIL reset_wb_count got %0h want 0", wb_count); end
    for (int i = 0; i < 15; i++) begin
      RA = i[3:0]; #1;
      checks++; if (PA !== 32'd0) begin errors++; $display("FAIL reset_reg R%0d got %08h want 0", i, PA); end
    end
    reset = 1'b0;
  endtask

  task automatic test_write();
    RF_EN = 1'b1; Rd_In = 4'd3; LoadInst = 1'b0; NonLoadDataIn = 32'hDEADBEEF; DataIn = 32'h0BADF00D;
    tick();
    RF_EN = 1'b0; RA = 4'd3; #1;
    checks++; if (PA !== 32'hDEADBEEF) begin errors++; $display("FAIL write_r3 got %08h want deadbeef", PA); end
    checks++; if (wb_count !== 16'd1) begin errors++; $display("FAIL write_count got %0d want 1", wb_count); end
  endtask

  task automatic test_bypass();
    RF_EN = 1'b1; Rd_In = 4'd5; LoadInst = 1'b1; DataIn = 32'h12345678; NonLoadDataIn = 32'h0;
    RB = 4'd5; RA = 4'd3; #1;
    checks++; if (PB !== 32'h12345678) begin errors++; $display("FAIL bypass_pb got %08h want 12345678", PB); end
    checks++; if (PA !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass_other_port got %08h want deadbeef", PA); end
    tick();
    RF_EN = 1'b0; #1;
    checks++; if (PB !== 32'h12345678) begin errors++; $display("FAIL bypass_stored got %08h want 12345678", PB); end
    checks++; if (wb_count !== 16'd2) begin errors++; $display("FAIL bypass_count got %0d want 2", wb_count); end
  endtask

  task automatic test_r15_write();
    RF_EN = 1'b1; Rd_In = 4'd15; LoadInst = 1'b0; NonLoadDataIn = 32'h00000100;
    tick();
    RF_EN = 1'b0;
    checks++; if (PC_Load !== 1'b1) begin errors++; $display("FAIL r15_pulse got %0h want 1", PC_Load); end
    checks++; if (PC_Target !== 32'h100) begin errors++; $display("FAIL r15_target got %08h want 100", PC_Target); end
    checks++; if (wb_count !== 16'd3) begin errors++; $display("FAIL r15_count got %0d want 3", wb_count); end
    for (int i = 0; i < 15; i++) begin
      logic [31:0] exp_v;
      exp_v = (i == 3) ? 32'hDEADBEEF : (i == 5) ? 32'h12345678 : 32'd0;
      RA = i[3:0]; #1;
      checks++; if (PA !== exp_v) begin errors++; $display("FAIL r15_regs_unchanged R%0d got %08h want %08h", i, PA, exp_v); end
    end
    tick();
    checks++; if (PC_Load !== 1'b0) begin errors++; $display("FAIL r15_pulse_end got %0h want 0", PC_Load); end
    checks++; if (PC_Target !== 32'h100) begin errors++; $display("FAIL r15_target_hold got %08h want 100", PC_Target); end
  endtask

  task automatic test_pc_read();
    PC_In = 32'h40; RC = 4'd15; RA = 4'd15; RB = 4'd15; #1;
    checks++; if (PC_Out !== 32'h48) begin errors++; $display("FAIL pc_read got %08h want 48", PC_Out); end
    RF_EN = 1'b1; Rd_In = 4'd15; LoadInst = 1'b0; NonLoadDataIn = 32'h200; #1;
    checks++; if (PC_Out !== 32'h48) begin errors++; $display("FAIL pc_read_no_bypass got %08h want 48", PC_Out); end
    checks++; if (PA !== 32'h48 || PB !== 32'h48) begin errors++; $display("FAIL pc_read_all_ports got %08h/%08h want 48", PA, PB); end
    tick();
    RF_EN = 1'b0;
    checks++; if (PC_Target !== 32'h200) begin errors++; $display("FAIL pc_read_target got %08h want 200", PC_Target); end
    PC_In = 32'hFFFFFFFC; #1;
    checks++; if (PC_Out !== 32'h4) begin errors++; $display("FAIL pc_read_wrap got %08h want 4", PC_Out); end
  endtask

  task automatic test_back_to_back();
    RF_EN = 1'b1; Rd_In = 4'd15; LoadInst = 1'b0; NonLoadDataIn = 32'h300;
    tick();
    checks++; if (PC_Load !== 1'b1 || PC_Target !== 32'h300) begin errors++; $display("FAIL b2b_first got %0h/%08h want 1/300", PC_Load, PC_Target); end
    LoadInst = 1'b1; DataIn = 32'h400;
    tick();
    checks++; if (PC_Load !== 1'b1 || PC_Target !== 32'h400) begin errors++; $display("FAIL b2b_second got %0h/%08h want 1/400", PC_Load, PC_Target); end
    RF_EN = 1'b0;
    tick();
    checks++; if (PC_Load !== 1'b0 || PC_Target !== 32'h400) begin errors++; $display("FAIL b2b_end got %0h/%08h want 0/400", PC_Load, PC_Target); end
    checks++; if (wb_count !== 16'd6) begin errors++; $display("FAIL b2b_count got %0d want 6", wb_count); end
  endtask

  task automatic test_same_address();
    RF_EN = 1'b1; Rd_In = 4'd3; LoadInst = 1'b0; NonLoadDataIn = 32'hA5A5A5A5;
    RA = 4'd3; RB = 4'd3; RC = 4'd3; #1;
    checks++; if (PA !== 32'hA5A5A5A5 || PB !== 32'hA5A5A5A5 || PC_Out !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL same_addr_bypass got %08h/%08h/%08h want a5a5a5a5", PA, PB, PC_Out); end
    tick();
    RF_EN = 1'b0; #1;
    checks++; if (PA !== 32'hA5A5A5A5 || PB !== 32'hA5A5A5A5 || PC_Out !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL same_addr_stored got %08h/%08h/%08h want a5a5a5a5", PA, PB, PC_Out); end
  endtask

  task automatic test_reset_priority();
    RF_EN = 1'b1; Rd_In = 4'd2; LoadInst = 1'b0; NonLoadDataIn = 32'h22222222;
    tick();
    checks++; if (wb_count !== 16'd8) begin errors++; $display("FAIL prio_precount got %0d want 8", wb_count); end
    reset = 1'b1; NonLoadDataIn = 32'hFFFFFFFF; RA = 4'd2; #1;
    checks++; if (PA !== 32'h22222222) begin errors++; $display("FAIL prio_no_bypass got %08h want 22222222", PA); end
    tick();
    reset = 1'b0; RF_EN = 1'b0; #1;
    checks++; if (PA !== 32'd0) begin errors++; $display("FAIL prio_r2_cleared got %08h want 0", PA); end
    checks++; if (wb_count !== 16'd0) begin errors++; $display("FAIL prio_count got %0d want 0", wb_count); end
    checks++; if (PC_Target !== 32'd0) begin errors++; $display("FAIL prio_target got %08h want 0", PC_Target); end
  endtask

  task automatic test_reset_after_r15();
    RF_EN = 1'b1; Rd_In = 4'd15; LoadInst = 1'b0; NonLoadDataIn = 32'h500;
    tick();
    reset = 1'b1; RF_EN = 1'b0; #1;
    checks++; if (PC_Load !== 1'b1 || PC_Target !== 32'h500) begin errors++; $display("FAIL rst_r15_pulse got %0h/%08h want 1/500", PC_Load, PC_Target); end
    tick();
    reset = 1'b0;
    checks++; if (PC_Load !== 1'b0 || PC_Target !== 32'd0 || wb_count !== 16'd0) begin
      errors++; $display("FAIL rst_r15_cleared got %0h/%08h/%0d want 0/0/0", PC_Load, PC_Target, wb_count); end
  endtask

  task automatic test_saturation();
    RF_EN = 1'b1; Rd_In = 4'd1; LoadInst = 1'b0; NonLoadDataIn = 32'h1;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 65533) begin
        checks++; if (wb_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %04h want fffe", wb_count); end
      end
    end
    checks++; if (wb_count !== 16'hFFFF) begin errors++; $display("FAIL sat_reached got %04h want ffff", wb_count); end
    RF_EN = 1'b0;
    tick();
    checks++; if (wb_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %04h want ffff", wb_count); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_write();
    test_bypass();
    test_r15_write();
    test_pc_read();
    test_back_to_back();
    test_same_address();
    test_reset_priority();
    test_reset_after_r15();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
